// File: rtl/fillrect.sv
// -----------------------------------------------------------------------------
// fillrect
//
// Rectangle fill engine. Plots one pixel per clock over the clipped rectangle
// [min(x0,x1)..max(x0,x1)] x [min(y0,y1)..max(y0,y1)]. The VGA adapter plot port
// is driven directly. Rows are scanned in the inner loop and columns in the
// outer loop. Colour is either solid or a per-column gradient that wraps
// modulo 2**COLOUR_W.
//
// Optional feature macro: FILLRECT_PIXCOUNT_EN
//   When defined, an extra output pix_count counts plotted pixels of the
//   current fill. It is cleared when a fill is launched and held in DONE.
//
// Parameters
//   SCREEN_W, SCREEN_H  visible screen size (coordinates at or beyond are off-screen)
//   X_W, Y_W            coordinate widths
//   COLOUR_W            colour width
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset, aborts any fill in progress
//   start       level request, sampled only while idle
//   x0, x1      column bounds (either order)
//   y0, y1      row bounds (either order)
//   colour      base colour
//   mode        0 = solid, 1 = column gradient
//   done        fill complete, held until start drops
//   vga_x       plot column
//   vga_y       plot row
//   vga_colour  plot colour
//   vga_plot    pixel write strobe
//   pix_count   (FILLRECT_PIXCOUNT_EN only) plotted pixel count
// -----------------------------------------------------------------------------
module fillrect #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y0,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                mode,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
`ifdef FILLRECT_PIXCOUNT_EN
  ,
  output logic [X_W+Y_W-1:0]  pix_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  // Counters and bounds carry one extra bit so comparisons at the top of
  // the coordinate range never wrap.
  localparam logic [X_W:0] X_LAST  = (X_W+1)'(SCREEN_W - 1);
  localparam logic [X_W:0] X_LIMIT = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LAST  = (Y_W+1)'(SCREEN_H - 1);
  localparam logic [Y_W:0] Y_LIMIT = (Y_W+1)'(SCREEN_H);

  state_t              state, state_n;
  logic [X_W:0]        x_cnt, x_cnt_n;
  logic [Y_W:0]        y_cnt, y_cnt_n;
  logic [X_W:0]        xmin_r, xmin_n, xmax_r, xmax_n;
  logic [Y_W:0]        ymin_r, ymin_n, ymax_r, ymax_n;
  logic [COLOUR_W-1:0] base_r, base_n;
  logic                mode_r, mode_n;
  logic                done_n;
  logic                plot_n;
  logic [COLOUR_W-1:0] colour_n;

  // Normalised and clipped view of the live inputs, used only at launch.
  logic [X_W:0] in_x0, in_x1, in_xlo, in_xhi_raw, in_xhi;
  logic [Y_W:0] in_y0, in_y1, in_ylo, in_yhi_raw, in_yhi;
  logic         in_offscreen;

  always_comb begin
    in_x0      = {1'b0, x0};
    in_x1      = {1'b0, x1};
    in_y0      = {1'b0, y0};
    in_y1      = {1'b0, y1};
    in_xlo     = (in_x0 <= in_x1) ? in_x0 : in_x1;
    in_xhi_raw = (in_x0 <= in_x1) ? in_x1 : in_x0;
    in_ylo     = (in_y0 <= in_y1) ? in_y0 : in_y1;
    in_yhi_raw = (in_y0 <= in_y1) ? in_y1 : in_y0;
    in_xhi     = (in_xhi_raw > X_LAST) ? X_LAST : in_xhi_raw;
    in_yhi     = (in_yhi_raw > Y_LAST) ? Y_LAST : in_yhi_raw;
    // A rectangle whose low corner is off-screen has nothing visible.
    in_offscreen = (in_xlo >= X_LIMIT) || (in_ylo >= Y_LIMIT);
  end

  // Next-state and next-output logic. Every output is a flop loaded from
  // these next values, so the plot port changes only on clock edges.
  always_comb begin
    state_n  = state;
    x_cnt_n  = x_cnt;
    y_cnt_n  = y_cnt;
    xmin_n   = xmin_r;
    xmax_n   = xmax_r;
    ymin_n   = ymin_r;
    ymax_n   = ymax_r;
    base_n   = base_r;
    mode_n   = mode_r;
    done_n   = done;
    plot_n   = 1'b0;
    colour_n = vga_colour;

    unique case (state)
      IDLE: begin
        done_n = 1'b0;
        if (start) begin
          xmin_n  = in_xlo;
          xmax_n  = in_xhi;
          ymin_n  = in_ylo;
          ymax_n  = in_yhi;
          base_n  = colour;
          mode_n  = mode;
          x_cnt_n = in_xlo;
          y_cnt_n = in_ylo;
          if (in_offscreen) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n  = FILL;
            plot_n   = 1'b1;
            colour_n = colour;
          end
        end
      end

      FILL: begin
        if ((x_cnt == xmax_r) && (y_cnt == ymax_r)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          plot_n = 1'b1;
          if (y_cnt == ymax_r) begin
            y_cnt_n = ymin_r;
            x_cnt_n = x_cnt + 1'b1;
          end else begin
            y_cnt_n = y_cnt + 1'b1;
          end
          // Gradient offset is the column distance from the left edge,
          // truncated so the colour wraps naturally.
          if (mode_r) begin
            colour_n = base_r + COLOUR_W'(x_cnt_n - xmin_r);
          end else begin
            colour_n = base_r;
          end
        end
      end

      DONE: begin
        done_n = 1'b1;
        if (!start) begin
          state_n = IDLE;
          done_n  = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
        done_n  = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset aborts a fill immediately and
  // silences the plot strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      xmin_r     <= '0;
      xmax_r     <= '0;
      ymin_r     <= '0;
      ymax_r     <= '0;
      base_r     <= '0;
      mode_r     <= 1'b0;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_colour <= '0;
    end else begin
      state      <= state_n;
      x_cnt      <= x_cnt_n;
      y_cnt      <= y_cnt_n;
      xmin_r     <= xmin_n;
      xmax_r     <= xmax_n;
      ymin_r     <= ymin_n;
      ymax_r     <= ymax_n;
      base_r     <= base_n;
      mode_r     <= mode_n;
      done       <= done_n;
      vga_plot   <= plot_n;
      vga_colour <= colour_n;
    end
  end

  assign vga_x = x_cnt[X_W-1:0];
  assign vga_y = y_cnt[Y_W-1:0];

`ifdef FILLRECT_PIXCOUNT_EN
  // Counts cycles whose plot strobe is high; cleared as a fill launches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_count <= '0;
    end else if ((state == IDLE) && start) begin
      pix_count <= '0;
    end else if (vga_plot) begin
      pix_count <= pix_count + 1'b1;
    end
  end
`endif

endmodule
